// File: rtl/conv_stream_pkg.sv
// conv_stream_pkg: shared FSM states, stride encodings and window index mapping for the window streamer
package conv_stream_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic STRIDE1 = 1'b0;
    localparam logic STRIDE2 = 1'b1;

    function automatic int unsigned win_idx(input int unsigned dy, input int unsigned dx);
        return 3 * dy + dx;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// line_buffer: one-row circular store with combinational read and registered write, read-before-write
module line_buffer #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 16,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              CLK,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    // the old value is read this cycle while the new one lands at the clock edge
    always_ff @(posedge CLK) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end

endmodule

// File: rtl/conv_window_streamer.sv
// conv_window_streamer: raster pixel stream to zero-padded 3x3 windows with stride 1 or 2
module conv_window_streamer
    import conv_stream_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int MAX_COLS = 64,
    parameter int MAX_ROWS = 64,
    localparam int CW  = $clog2(MAX_COLS + 1),
    localparam int RW  = $clog2(MAX_ROWS + 1),
    localparam int OCW = $clog2(MAX_COLS),
    localparam int ORW = $clog2(MAX_ROWS)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic [CW-1:0]       cfg_cols,
    input  logic [RW-1:0]       cfg_rows,
    input  logic                cfg_stride2,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [9*DATA_W-1:0] out_window,
    output logic [ORW-1:0]      out_row,
    output logic [OCW-1:0]      out_col,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done,
    output logic                cfg_err
);

    localparam logic [CW-1:0] MAXC = CW'(MAX_COLS);
    localparam logic [RW-1:0] MAXR = RW'(MAX_ROWS);

    state_t              r_state, w_next;
    logic [CW-1:0]       r_cols, r_col;
    logic [RW-1:0]       r_rows, r_row;
    logic                r_stride2, r_end, r_cfg_err, r_out_valid;
    logic [DATA_W-1:0]   r_win [3][3];
    logic [DATA_W-1:0]   w_nw [3][3];
    logic [DATA_W-1:0]   w_col [3];
    logic [DATA_W-1:0]   w_lb0_rd, w_lb1_rd, w_sample;
    logic [9*DATA_W-1:0] r_out_window, w_window;
    logic [ORW-1:0]      r_out_row, w_crow;
    logic [OCW-1:0]      r_out_col, w_ccol;
    logic                w_cfg_ok, w_ext, w_in_col, w_slot, w_adv, w_emit, w_last_col;

    assign w_cfg_ok   = (cfg_cols != '0) && (cfg_cols <= MAXC) && (cfg_rows != '0) && (cfg_rows <= MAXR);
    assign w_in_col   = r_col < r_cols;
    assign w_ext      = (r_row < r_rows) && w_in_col;
    assign w_slot     = !r_out_valid || out_ready;
    assign w_last_col = r_col == r_cols;
    assign w_sample   = w_ext ? in_data : '0;
    assign w_col[0]   = w_in_col ? w_lb1_rd : '0;
    assign w_col[1]   = w_in_col ? w_lb0_rd : '0;
    assign w_col[2]   = w_sample;
    assign w_crow     = ORW'(r_row - 1'b1);
    assign w_ccol     = OCW'(r_col - 1'b1);
    assign w_emit     = w_adv && (r_row != '0) && (r_col != '0) &&
                        (r_stride2 == STRIDE1 || r_row[0]) && (r_stride2 == STRIDE1 || r_col[0]);

    assign out_window = r_out_window;
    assign out_row    = r_out_row;
    assign out_col    = r_out_col;
    assign out_valid  = r_out_valid;
    assign cfg_err    = r_cfg_err;

    // lb0 holds the previous scan row, lb1 the one before; the right padding column never touches them
    line_buffer #(.DEPTH(MAX_COLS), .DATA_W(DATA_W)) u_lb0 (
        .CLK     (CLK),
        .i_we    (w_adv && w_in_col),
        .i_addr  (r_col[OCW-1:0]),
        .i_wdata (w_sample),
        .o_rdata (w_lb0_rd)
    );

    line_buffer #(.DEPTH(MAX_COLS), .DATA_W(DATA_W)) u_lb1 (
        .CLK     (CLK),
        .i_we    (w_adv && w_in_col),
        .i_addr  (r_col[OCW-1:0]),
        .i_wdata (w_lb0_rd),
        .o_rdata (w_lb1_rd)
    );

    // next state plus handshake/status outputs; advancing stops once the last scan position is taken
    always_comb begin
        w_next   = r_state;
        in_ready = (r_state == RUN) && w_ext && w_slot;
        w_adv    = (r_state == RUN) && !r_end && w_slot && (!w_ext || in_valid);
        busy     = r_state != IDLE;
        done     = r_state == DONE;
        w_next   = (r_state == IDLE && start && w_cfg_ok)    ? RUN  :
                   (r_state == RUN && r_end && !r_out_valid) ? DONE :
                   (r_state == DONE)                          ? IDLE : r_state;
    end

    // state register
    always_ff @(posedge CLK) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // frame configuration latch and extended raster scan position
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cols    <= '0;
            r_rows    <= '0;
            r_stride2 <= STRIDE1;
            r_col     <= '0;
            r_row     <= '0;
            r_end     <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= (r_state == IDLE) && start && !w_cfg_ok;
            if (r_state == IDLE && start && w_cfg_ok) begin
                r_cols    <= cfg_cols;
                r_rows    <= cfg_rows;
                r_stride2 <= cfg_stride2;
                r_col     <= '0;
                r_row     <= '0;
                r_end     <= 1'b0;
            end else if (w_adv) begin
                r_col <= w_last_col ? '0 : r_col + 1'b1;
                r_row <= (w_last_col && r_row != r_rows) ? r_row + 1'b1 : r_row;
                r_end <= w_last_col && (r_row == r_rows);
            end
        end
    end

    // window contents after this advance: older columns slide left, new column enters at dx=2
    always_comb begin
        for (int dy = 0; dy < 3; dy++) begin
            w_nw[dy][0] = r_win[dy][1];
            w_nw[dy][1] = r_win[dy][2];
            w_nw[dy][2] = w_col[dy];
        end
    end

    // pack the window, blanking the row above centre row 0 and the column left of centre column 0
    always_comb begin
        w_window = '0;
        for (int dy = 0; dy < 3; dy++) begin
            for (int dx = 0; dx < 3; dx++) begin
                w_window[int'(win_idx(dy, dx))*DATA_W +: DATA_W] =
                    ((dy == 0 && w_crow == '0) || (dx == 0 && w_ccol == '0)) ? '0 : w_nw[dy][dx];
            end
        end
    end

    // shift window register
    always_ff @(posedge CLK) begin
        if (w_adv) r_win <= w_nw;
    end

    // output register; only reloaded when the slot is free so held windows stay stable
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out_valid  <= 1'b0;
            r_out_window <= '0;
            r_out_row    <= '0;
            r_out_col    <= '0;
        end else if (w_emit) begin
            r_out_valid  <= 1'b1;
            r_out_window <= w_window;
            r_out_row    <= w_crow;
            r_out_col    <= w_ccol;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_streamer.sv
// tb_conv_window_streamer: scoreboard bench for the 3x3 window streamer
module tb_conv_window_streamer;

    logic         CLK = 1'b0;
    logic         RST, start, cfg_stride2, in_valid, in_ready, out_valid, out_ready, busy, done, cfg_err;
    logic [6:0]   cfg_cols, cfg_rows;
    logic [15:0]  in_data;
    logic [143:0] out_window, last_win;
    logic [5:0]   out_row, out_col;

    typedef struct {
        logic [143:0] win;
        logic [5:0]   row;
        logic [5:0]   col;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [15:0] pix [4096];
    int          n_chk = 0, n_fail = 0, win_cnt = 0, done_cnt = 0;

    conv_window_streamer #(.DATA_W(16), .MAX_COLS(64), .MAX_ROWS(64)) dut (
        .CLK(CLK), .RST(RST), .start(start), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
        .cfg_stride2(cfg_stride2), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_window(out_window), .out_row(out_row), .out_col(out_col), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge CLK) begin
        if (done) done_cnt++;
        if (out_valid && out_ready) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_window: got (%0d,%0d) %h, expected no window", out_row, out_col, out_window);
            end else begin
                e = exp_q.pop_front();
                if (out_window !== e.win || out_row !== e.row || out_col !== e.col) begin
                    n_fail++;
                    $display("FAIL window: got (%0d,%0d) %h, expected (%0d,%0d) %h",
                             out_row, out_col, out_window, e.row, e.col, e.win);
                end
            end
            last_win = out_window;
            win_cnt++;
        end
    end

    task automatic push_model(input int rows, input int cols, input int s);
        exp_t m;
        for (int y = 0; y < rows; y++) begin
            for (int x = 0; x < cols; x++) begin
                if (y % s == 0 && x % s == 0) begin
                    m.win = '0;
                    for (int dy = 0; dy < 3; dy++) begin
                        for (int dx = 0; dx < 3; dx++) begin
                            int yy = y + dy - 1;
                            int xx = x + dx - 1;
                            if (yy >= 0 && yy < rows && xx >= 0 && xx < cols)
                                m.win[(3*dy+dx)*16 +: 16] = pix[yy*cols+xx];
                        end
                    end
                    m.row = 6'(y);
                    m.col = 6'(x);
                    exp_q.push_back(m);
                end
            end
        end
    endtask

    task automatic start_frame(input int rows, input int cols, input int s);
        cfg_rows    = 7'(rows);
        cfg_cols    = 7'(cols);
        cfg_stride2 = (s == 2);
        push_model(rows, cols, s);
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic send_pixels(input int first, input int n, input bit gaps);
        for (int i = first; i < first + n; i++) begin
            int t = 0;
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge CLK);
                #1;
            end
            in_data  = pix[i];
            in_valid = 1'b1;
            @(negedge CLK);
            while (!in_ready && t < 2000) begin
                @(negedge CLK);
                t++;
            end
            @(posedge CLK); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_done(output bit ok);
        int d0 = done_cnt;
        int t  = 0;
        while (done_cnt == d0 && t < 5000) begin
            @(negedge CLK);
            t++;
        end
        ok = done_cnt != d0;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        cfg_cols = '0; cfg_rows = '0; cfg_stride2 = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_chk++; if (out_window !== '0) begin n_fail++; $display("FAIL reset_out_window: got %h expected 0", out_window); end
        n_chk++; if ({out_row, out_col} !== 12'd0) begin n_fail++; $display("FAIL reset_coords: got %0d,%0d expected 0,0", out_row, out_col); end
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        n_chk++; if ({busy, done, cfg_err} !== 3'b000) begin n_fail++; $display("FAIL reset_status: got %b expected 000", {busy, done, cfg_err}); end
        @(posedge CLK); #1;
    endtask

    task automatic test_stride1();
        bit ok;
        int w0 = win_cnt;
        int d0 = done_cnt;
        int t  = 0;
        logic [143:0] w00 = {16'd6, 16'd5, 16'd0, 16'd2, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
        logic [143:0] w33 = {16'd0, 16'd0, 16'd0, 16'd0, 16'd16, 16'd15, 16'd0, 16'd12, 16'd11};
        for (int i = 0; i < 16; i++) pix[i] = 16'(i + 1);
        start_frame(4, 4, 1);
        send_pixels(0, 5, 1'b0);
        in_data = pix[5]; in_valid = 1'b1;
        @(negedge CLK);
        while (!in_ready && t < 100) begin @(negedge CLK); t++; end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_pre: out_valid got %b expected 0", out_valid); end
        @(posedge CLK); #1 in_valid = 1'b0;
        @(negedge CLK);
        n_chk++; if (out_valid !== 1'b1 || out_row !== 6'd0 || out_col !== 6'd0)
            begin n_fail++; $display("FAIL latency_post: valid %b at (%0d,%0d) expected 1 at (0,0)", out_valid, out_row, out_col); end
        n_chk++; if (out_window !== w00) begin n_fail++; $display("FAIL win00: got %h expected %h", out_window, w00); end
        @(posedge CLK); #1;
        send_pixels(6, 10, 1'b0);
        wait_done(ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL s1_done: got no done expected pulse"); end
        repeat (3) @(posedge CLK);
        #1;
        n_chk++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL s1_done_once: got %0d expected 1", done_cnt - d0); end
        n_chk++; if (win_cnt - w0 != 16) begin n_fail++; $display("FAIL s1_count: got %0d expected 16", win_cnt - w0); end
        n_chk++; if (last_win !== w33) begin n_fail++; $display("FAIL win33: got %h expected %h", last_win, w33); end
        n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL s1_left: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_stride2();
        bit ok;
        int w0 = win_cnt;
        logic [143:0] w22 = {16'd16, 16'd15, 16'd14, 16'd12, 16'd11, 16'd10, 16'd8, 16'd7, 16'd6};
        start_frame(4, 4, 2);
        send_pixels(0, 16, 1'b1);
        wait_done(ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL s2_done: got no done expected pulse"); end
        n_chk++; if (win_cnt - w0 != 4) begin n_fail++; $display("FAIL s2_count: got %0d expected 4", win_cnt - w0); end
        n_chk++; if (last_win !== w22) begin n_fail++; $display("FAIL win22: got %h expected %h", last_win, w22); end
        n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL s2_left: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int w0 = win_cnt;
        for (int i = 0; i < 30; i++) pix[i] = 16'($urandom);
        start_frame(5, 6, 1);
        fork
            send_pixels(0, 30, 1'b1);
            begin
                logic [143:0] cw;
                logic [5:0]   cr, cc;
                int t = 0;
                while (win_cnt < w0 + 4 && t < 1000) begin @(negedge CLK); t++; end
                @(posedge CLK); #1 out_ready = 1'b0;
                t = 0;
                @(negedge CLK);
                while (!out_valid && t < 100) begin @(negedge CLK); t++; end
                cw = out_window; cr = out_row; cc = out_col;
                for (int k = 0; k < 5; k++) begin
                    @(negedge CLK);
                    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
                    n_chk++; if (out_valid !== 1'b1 || out_window !== cw || out_row !== cr || out_col !== cc)
                        begin n_fail++; $display("FAIL bp_hold: got %b (%0d,%0d) %h expected 1 (%0d,%0d) %h",
                                                 out_valid, out_row, out_col, out_window, cr, cc, cw); end
                end
                @(posedge CLK); #1 out_ready = 1'b1;
            end
        join
        wait_done(ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL bp_done: got no done expected pulse"); end
        n_chk++; if (win_cnt - w0 != 30) begin n_fail++; $display("FAIL bp_count: got %0d expected 30", win_cnt - w0); end
        n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_left: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_wide_row();
        bit ok, stop;
        int w0 = win_cnt;
        int d0 = done_cnt;
        int nz = 0;
        stop = 1'b0;
        for (int i = 0; i < 64; i++) pix[i] = 16'($urandom_range(1, 65535));
        start_frame(1, 64, 1);
        fork
            begin
                send_pixels(0, 64, 1'b1);
                wait_done(ok);
                stop = 1'b1;
            end
            while (!stop) begin
                @(posedge CLK); #1 out_ready = 1'($urandom_range(0, 1));
            end
            while (!stop) begin
                @(negedge CLK);
                if (out_valid && out_ready && (out_window[47:0] != '0 || out_window[143:96] != '0)) nz++;
            end
        join
        out_ready = 1'b1;
        n_chk++; if (!ok) begin n_fail++; $display("FAIL wide_done: got no done expected pulse"); end
        n_chk++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL wide_done_once: got %0d expected 1", done_cnt - d0); end
        n_chk++; if (win_cnt - w0 != 64) begin n_fail++; $display("FAIL wide_count: got %0d expected 64", win_cnt - w0); end
        n_chk++; if (nz != 0) begin n_fail++; $display("FAIL wide_pad_rows: got %0d nonzero windows expected 0", nz); end
        n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL wide_left: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_degenerate();
        bit ok;
        int w0 = win_cnt;
        for (int i = 0; i < 3; i++) pix[i] = 16'(100 + i);
        start_frame(3, 1, 2);
        send_pixels(0, 3, 1'b0);
        wait_done(ok);
        n_chk++; if (!ok || win_cnt - w0 != 2) begin n_fail++; $display("FAIL col1_s2: got done %b count %0d expected 1 and 2", ok, win_cnt - w0); end
        w0 = win_cnt;
        start_frame(1, 1, 1);
        send_pixels(0, 1, 1'b0);
        wait_done(ok);
        n_chk++; if (!ok || win_cnt - w0 != 1) begin n_fail++; $display("FAIL one_px: got done %b count %0d expected 1 and 1", ok, win_cnt - w0); end
        n_chk++; if (last_win !== {16'd0, 16'd0, 16'd0, 16'd0, 16'd100, 16'd0, 16'd0, 16'd0, 16'd0})
            begin n_fail++; $display("FAIL one_px_win: got %h expected centre 100 only", last_win); end
    endtask

    task automatic test_cfg_err();
        for (int k = 0; k < 2; k++) begin
            cfg_cols = (k == 0) ? 7'd0 : 7'd4;
            cfg_rows = (k == 0) ? 7'd4 : 7'd65;
            start = 1'b1;
            @(posedge CLK); #1 start = 1'b0;
            @(negedge CLK);
            n_chk++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_err_pulse%0d: got %b expected 1", k, cfg_err); end
            n_chk++; if (busy !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL cfg_err_idle%0d: busy %b in_ready %b expected 0 0", k, busy, in_ready); end
            @(negedge CLK);
            n_chk++; if (cfg_err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL cfg_err_end%0d: cfg_err %b busy %b expected 0 0", k, cfg_err, busy); end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int w0;
        int d0 = done_cnt;
        for (int i = 0; i < 16; i++) pix[i] = 16'($urandom);
        start_frame(4, 4, 1);
        send_pixels(0, 7, 1'b0);
        RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        n_chk++; if ({out_valid, in_ready, busy, done, cfg_err} !== 5'b0) begin n_fail++; $display("FAIL rst_mid_status: got %b expected 00000", {out_valid, in_ready, busy, done, cfg_err}); end
        n_chk++; if (out_window !== '0 || out_row !== '0 || out_col !== '0) begin n_fail++; $display("FAIL rst_mid_data: got %h (%0d,%0d) expected zeros", out_window, out_row, out_col); end
        n_chk++; if (dut.r_state !== conv_stream_pkg::IDLE) begin n_fail++; $display("FAIL rst_mid_state: got %0d expected IDLE", dut.r_state); end
        exp_q.delete();
        @(posedge CLK); #1;
        w0 = win_cnt;
        for (int i = 0; i < 9; i++) pix[i] = 16'($urandom);
        start_frame(3, 3, 1);
        send_pixels(0, 9, 1'b1);
        wait_done(ok);
        n_chk++; if (!ok || done_cnt - d0 != 1) begin n_fail++; $display("FAIL rst_fresh_done: got %0d pulses expected 1", done_cnt - d0); end
        n_chk++; if (win_cnt - w0 != 9) begin n_fail++; $display("FAIL rst_fresh_count: got %0d expected 9", win_cnt - w0); end
        n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rst_fresh_left: got %0d expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_stride1();
        test_stride2();
        test_backpressure();
        test_wide_row();
        test_degenerate();
        test_cfg_err();
        test_reset_mid_frame();
        repeat (2) @(posedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_window_streamer.md
Name: conv_window_streamer

Overview:
- Parametrised successor to the fixed 3x3 conv input buffer.
- Takes a raster-order pixel stream of a runtime-sized frame (rows x cols ≤ MAX_ROWS x MAX_COLS) and emits complete 3x3 windows with implicit zero padding (pad=1, same-size output).
- Runtime stride is 1 or 2.
- Uses valid/ready handshakes on both sides; sits between feature-map memory and the conv PE array.

Parameters:
- DATA_W, 16, bits per pixel.
- MAX_COLS, 64, maximum row width; sets line-buffer depth.
- MAX_ROWS, 64, maximum frame height.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; latches cfg_* and starts a frame.
- cfg_cols  in  $clog2(MAX_COLS+1)  frame width.
- cfg_rows  in  $clog2(MAX_ROWS+1)  frame height.
- cfg_stride2  in  1  0 = stride 1, 1 = stride 2.
- in_data  in  DATA_W  pixel.
- in_valid  in  1  pixel valid.
- in_ready  out  1  pixel accepted when in_valid && in_ready.
- out_window  out  9*DATA_W  element k = 3*dy+dx; (dy,dx) = (0,0) is top-left; element 0 is in the LSBs.
- out_row, out_col  out  $clog2(MAX_ROWS), $clog2(MAX_COLS)  window centre coordinate.
- out_valid  out  1  window valid.
- out_ready  in  1  window consumed when out_valid && out_ready.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at end of frame.
- cfg_err  out  1  one-cycle pulse when start carries an illegal config.

Behaviour:
- Reset (RST sampled high at CLK):
  - All outputs go to 0 the next cycle and the FSM goes to IDLE.
  - Line-buffer contents are not cleared; edge masking makes them irrelevant.
  - RST mid-frame aborts the frame. No done pulse is issued.
- FSM states and transitions:
  - IDLE: on start, legal config → RUN; illegal config → cfg_err pulse, stay IDLE.
  - Legal config: 1 ≤ cfg_cols ≤ MAX_COLS and 1 ≤ cfg_rows ≤ MAX_ROWS.
  - RUN: walks the extended scan positions (r,c), r in 0..rows, c in 0..cols, raster order.
  - RUN → DONE: after position (rows,cols) is processed and no window is pending.
  - DONE: pulses done for one cycle, then → IDLE.
  - start is ignored outside IDLE.
- Sample at position (r,c):
  - r<rows and c<cols: consumes one input pixel.
  - Otherwise: an internally generated 0, with no input consumed (bottom/right padding).
- Advance condition (one position per cycle): state==RUN && (!out_valid || out_ready) && (sample is internal || in_valid).
- in_ready = state==RUN && sample is external && (!out_valid || out_ready). No combinational path from in_valid to in_ready.
- Window assembly on each advance:
  - Sample enters the 3x3 shift window as the new bottom-right.
  - The column read from the two line buffers at c is shifted in.
  - The sample is written to line buffer c (read-before-write).
- Window emission:
  - The advance at (r,c) completes the window centred at (r-1,c-1).
  - It is emitted iff r≥1, c≥1, (r-1)%S==0 and (c-1)%S==0.
  - Emission loads out_window/out_row/out_col and sets out_valid the next cycle.
  - Latency: acceptance of pixel (y+1,x+1) → window (y,x) valid one cycle later.
- Edge masking: centre row 0 zeroes row dy=0; centre col 0 zeroes column dx=0.
- Output stability: out_* hold stable while out_valid && !out_ready. Simultaneous accept and new emission in the same cycle gives back-to-back valid windows.
- Window counts: stride 1 emits rows*cols windows; stride 2 emits ceil(rows/2)*ceil(cols/2) windows.
- Degenerate frames: rows=1 and/or cols=1 are legal; all neighbours are zero-padded.
- busy = state != IDLE.

Decomposition:
- Package conv_stream_pkg: FSM state enum {IDLE, RUN, DONE}; STRIDE1/STRIDE2 constants; the window index mapping function k = 3*dy+dx.
- Sub-module line_buffer: single-port-per-cycle circular RAM, depth MAX_COLS, width DATA_W, read-before-write at the same address. Instantiate twice.

Test Plan:
- 4x4 frame, pixels 1..16, stride 1, out_ready=1:
  - 16 windows produced.
  - Window (0,0) = {0,0,0, 0,1,2, 0,5,6}, with out_valid one cycle after pixel 6 is accepted.
  - Window (3,3) = {11,12,0, 15,16,0, 0,0,0}.
  - done pulses once.
- Same frame, cfg_stride2=1:
  - Exactly 4 windows, centres (0,0), (0,2), (2,0), (2,2).
  - Window (2,2) = {6,7,8, 10,11,12, 14,15,16}.
- Backpressure: out_ready low for 5 cycles mid-frame → in_ready=0; out_window, out_row and out_col unchanged; no pixel lost or duplicated. Compare against the reference model.
- cols=MAX_COLS, rows=1, random pixels → MAX_COLS windows; rows dy=0 and dy=2 are all zero; done pulses.
- start with cfg_cols=0, and again with cfg_rows=MAX_ROWS+1 → cfg_err pulses; busy stays 0; in_ready stays 0.
- RST asserted mid-frame at pixel 7 → next cycle all outputs are 0 and the FSM is in IDLE. A fresh 3x3 frame then yields windows exactly matching the model, with no stale data.
